// File: rtl/seq_pkg.sv
// Shared types and constants for the serial sequence feeder and detector.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SEQ_WIDTH = 8;
    localparam int SEQ_DEPTH = 4;
    // Matches the detector's count output width.
    localparam int SEQ_CNT_W = 16;

endpackage

// File: rtl/seq_fifo.sv
// Synchronous FIFO with an occupancy counter; head word is readable combinationally.
module seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             do_push;
    logic             do_pop;

    assign full     = (occ == OCC_W'(DEPTH));
    assign empty    = (occ == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder: FIFO-buffered words shifted out MSB-first, one bit per cycle.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int DEPTH = SEQ_DEPTH
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [WIDTH-1:0]     DataIn,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic                 Hold,
    output logic                 SerOut,
    output logic                 SerValid,
    output logic [SEQ_CNT_W-1:0] BytesSent
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    ser_state_t           state_q, state_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SEQ_CNT_W-1:0] sent_d;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WIDTH-1:0]     fifo_data;

    seq_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (InValid && !fifo_full),
        .push_data (DataIn),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign InReady  = !fifo_full;
    assign SerOut   = (state_q == SHIFT) ? shift_q[WIDTH-1] : 1'b0;
    assign SerValid = (state_q == SHIFT) && !Hold;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            BytesSent <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            BytesSent <= sent_d;
        end
    end

    // Pops look at registered occupancy, so a word pushed this edge is loaded next edge.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        sent_d  = BytesSent;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !Hold) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!Hold) begin
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        sent_d = BytesSent + SEQ_CNT_W'(1);
                        cnt_d  = '0;
                        // Reload straight from the FIFO to avoid a bubble between words.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Upstream feeder for the serial sequence detector. Accepts parallel bytes over a valid/ready handshake, buffers them in a small FIFO, and emits them MSB-first as a one-bit-per-cycle stream. Its serial output drives the detector's `InA` input directly. A wrap-around count of fully transmitted bytes is kept for bench cross-checking.

## Interface
- `WIDTH`, 8: bits per parallel word.
- `DEPTH`, 4: FIFO entries; a power of two, at least 2.
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset. Low clears all state immediately, independent of `Clk`.
- `DataIn`  in  WIDTH  parallel word to serialize.
- `InValid`  in  1  `DataIn` is valid this cycle.
- `InReady`  out  1  FIFO can accept a word. Equals `!full`, combinational from FIFO occupancy.
- `Hold`  in  1  pauses shifting; FIFO pushes are still accepted.
- `SerOut`  out  1  serial bit; connects to the detector's `InA`.
- `SerValid`  out  1  `SerOut` carries a real bit this cycle.
- `BytesSent`  out  16  count of words whose last bit has been emitted; wraps from 16'hFFFF to 0.

## Operation
- Push: when `InValid && InReady` at a rising edge, `DataIn` is written to the FIFO tail.
- When full, `InReady`=0 and `InValid` is ignored. A push at full is never accepted, even if a pop occurs in the same cycle.
- FSM has two states, IDLE and SHIFT.
- IDLE: `SerValid`=0, `SerOut`=0.
  - If the FIFO is non-empty and `Hold`=0, pop the head into the shift register, clear the bit counter, and go to SHIFT.
- SHIFT: `SerOut` = shift register MSB, `SerValid`=1 unless `Hold`=1.
  - Each non-held edge shifts left by one and increments the bit counter, which is `$clog2(WIDTH)` bits wide.
  - On the edge that retires bit WIDTH-1, increment `BytesSent`.
  - On that same edge, if the FIFO is non-empty, pop the next word directly into the shift register and stay in SHIFT, so there is no bubble. Otherwise go to IDLE.
- Hold in SHIFT: shift register, bit counter and state are frozen; `SerValid`=0; `SerOut` holds its current bit.
- Hold in IDLE: no load occurs.
- Simultaneous push to an empty FIFO and pop: not possible. The pop checks occupancy before the push, so the new word is loaded on the following edge.
- Reset mid-operation: the partial word, all FIFO contents and the counters are discarded. The FSM returns to IDLE.

## Timing
- Reset values: `SerOut`=0, `SerValid`=0, `BytesSent`=0, `InReady`=1, FSM in IDLE, FIFO empty.
- Latency, with an empty FIFO, IDLE and `Hold`=0:
  - A word accepted at edge N is popped at edge N+1.
  - Its MSB is valid on `SerOut` after edge N+1.
  - Its LSB is valid after edge N+WIDTH.
  - `BytesSent` updates at edge N+WIDTH+1.
- Back-to-back words with `Hold`=0 give a continuous `SerValid`=1 stream of WIDTH×k cycles.
- Throughput is one bit per cycle, i.e. one word per WIDTH cycles. The FIFO absorbs input bursts up to DEPTH words plus the word in the shifter.
- `InReady` deasserts in the same cycle the FIFO occupancy reaches DEPTH.

## Structure
- Shared package `seq_pkg`:
  - state typedef `ser_state_t` {IDLE, SHIFT};
  - default constants `SEQ_WIDTH`=8 and `SEQ_DEPTH`=4;
  - counter width constant `SEQ_CNT_W`=16, shared with the detector's count output.
- One sub-module, `seq_fifo`: a synchronous FIFO with WIDTH and DEPTH parameters, push/pop, full/empty flags, pointer wrap via a log2(DEPTH)+1-bit occupancy counter, and the same async active-low `Reset`.
- The top level holds the FSM, the shift register, the bit counter and `BytesSent`.

## Test plan
- Reset held low, then released with no input: `SerValid`=0, `SerOut`=0, `InReady`=1 and `BytesSent`=0 for 20 cycles.
- Single push of 8'h85: `SerOut` = 1,0,0,0,0,1,0,1 on the 8 cycles after the accept edge, `SerValid`=1 throughout. `BytesSent`=1 afterwards, then IDLE.
- Burst 8'h85, 8'h97, 8'h42, 8'h53, 8'h28 with `InValid` held: exactly 40 contiguous `SerValid` cycles. The bit stream matches the 40-bit MSB-first concatenation. `BytesSent`=5. Feeding the detector yields the count it expects for the same pattern.
- Overflow: `Hold`=1, push 6 words. The first 4 are accepted and `InReady` falls to 0 after the 4th. Words 5 and 6 are ignored. Releasing `Hold` emits exactly 32 bits of words 1–4.
- Hold mid-word: on 8'h97, assert `Hold` after bit 3 for 5 cycles. `SerValid`=0 and `SerOut` is stable during the hold. Emission resumes with bit 4, no bit is lost or duplicated, and the total stays at 8 valid bits.
- Async reset mid-word: drive `Reset` low between edges during bit 4 of 8'h53 with 2 words queued. All outputs return to reset values before the next edge. After release the FIFO is empty, `BytesSent`=0, and no residual bits appear.
